// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Holds the arbiter state and grant encodings.
package mem_arb_pkg;

  localparam int ARB_XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_DM   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } arb_gnt_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: data port first, unless the fetch port
// has been starved long enough to be forced through.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic     if_req_i,
  input  logic     dm_req_i,
  input  logic     force_if_i,
  output arb_gnt_e gnt_o
);

  // force_if only matters while a fetch is actually waiting; otherwise a
  // saturated counter would lock out a lone data request.
  always_comb begin
    gnt_o = GNT_NONE;
    if (dm_req_i && !(force_if_i && if_req_i)) begin
      gnt_o = GNT_DM;
    end else if (if_req_i) begin
      gnt_o = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/DM arbiter for one single-port memory with req/ack sequencing and stalls.
// Optional ack timeout with sticky err_o: define ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN           = ARB_XLEN,
  parameter int MAX_STARVE     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic [XLEN-1:0] if_rdata_o,
  output logic            if_valid_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [XLEN-1:0] dm_addr_i,
  input  logic [XLEN-1:0] dm_wdata_i,
  output logic [XLEN-1:0] dm_rdata_o,
  output logic            dm_valid_o,
  output logic            stall_if_o,
  output logic            stall_dm_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            err_o,
  output arb_state_e      dbg_state_o
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  // Handshake: mem_req_o rises on a grant and holds until mem_ack_i is seen
  // at an edge; that edge drops mem_req_o and pulses the owner's valid for
  // one cycle. Requesters hold req/addr until their valid pulse.
  arb_state_e      r_state;
  logic [SW-1:0]   r_starve;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [XLEN-1:0] r_if_rdata;
  logic [XLEN-1:0] r_dm_rdata;
  logic            r_if_valid;
  logic            r_dm_valid;
  logic            w_force_if;
  arb_gnt_e        w_gnt;

  assign w_force_if = (r_starve == SW'(MAX_STARVE));

  mem_arb_pick u_pick (
    .if_req_i   (if_req_i),
    .dm_req_i   (dm_req_i),
    .force_if_i (w_force_if),
    .gnt_o      (w_gnt)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_err;
  assign err_o = r_err;
`else
  // No timeout in this build: the flag can never set.
  assign err_o = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ARB_IDLE;
      r_starve    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          case (w_gnt)
            GNT_DM: begin
              r_state     <= ARB_DM;
              r_mem_req   <= 1'b1;
              r_mem_we    <= dm_we_i;
              r_mem_addr  <= dm_addr_i;
              r_mem_wdata <= dm_wdata_i;
              if (!if_req_i)       r_starve <= '0;
              else if (!w_force_if) r_starve <= r_starve + 1'b1;
`ifdef ARB_TIMEOUT_EN
              r_to_cnt    <= '0;
`endif
            end
            GNT_IF: begin
              r_state    <= ARB_IF;
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= if_addr_i;
              r_starve   <= '0;
`ifdef ARB_TIMEOUT_EN
              r_to_cnt   <= '0;
`endif
            end
            default: ;
          endcase
        end
        ARB_IF, ARB_DM: begin
          if (mem_ack_i) begin
            r_state   <= ARB_IDLE;
            r_mem_req <= 1'b0;
            if (r_state == ARB_IF) begin
              r_if_valid <= 1'b1;
              r_if_rdata <= mem_rdata_i;
            end else begin
              r_dm_valid <= 1'b1;
              if (!r_mem_we) r_dm_rdata <= mem_rdata_i;
            end
`ifdef ARB_TIMEOUT_EN
          end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the access: release the requester without new data.
            r_state   <= ARB_IDLE;
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            if (r_state == ARB_IF) r_if_valid <= 1'b1;
            else                   r_dm_valid <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign if_valid_o  = r_if_valid;
  assign dm_valid_o  = r_dm_valid;
  assign stall_if_o  = if_req_i & ~r_if_valid;
  assign stall_dm_o  = dm_req_i & ~r_dm_valid;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, and a
// randomized run against a behavioural model. Timeout case needs ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int XLEN       = 32;
  localparam int MAX_STARVE = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic            if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [XLEN-1:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic            ack_drv = 1'b0, comb_mode = 1'b0;
  logic [XLEN-1:0] rdata_drv = '0;
  logic            mem_ack_w;
  logic [XLEN-1:0] mem_rdata_w;
  logic [XLEN-1:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic            if_valid_o, dm_valid_o, stall_if_o, stall_dm_o;
  logic            mem_req_o, mem_we_o, err_o;
  arb_state_e      dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  // Memory side: registered-style ack from drivers, or same-cycle ack.
  assign mem_ack_w   = comb_mode ? mem_req_o : ack_drv;
  assign mem_rdata_w = comb_mode ? (mem_addr_o ^ 32'hA5A5_0000) : rdata_drv;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_STARVE(MAX_STARVE), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
    .stall_if_o(stall_if_o), .stall_dm_o(stall_dm_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_w), .mem_rdata_i(mem_rdata_w), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got hang, need finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    ack_drv = 0; rdata_drv = '0; comb_mode = 0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            dm_req, dm_we;
    logic [XLEN-1:0] dm_addr, dm_wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;
    logic            e_req, e_we;
    logic [XLEN-1:0] e_addr, e_wdata;
    logic            e_ifv, e_dmv;
    logic [XLEN-1:0] e_ifd, e_dmd;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd, input logic ak,
                         input logic [31:0] rd, input logic er, input logic ew,
                         input logic [31:0] ea, input logic [31:0] ed, input logic eiv,
                         input logic edv, input logic [31:0] eid, input logic [31:0] edd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw; v.dm_addr = da; v.dm_wdata = dd;
    v.ack = ak; v.rdata = rd; v.e_req = er; v.e_we = ew; v.e_addr = ea; v.e_wdata = ed;
    v.e_ifv = eiv; v.e_dmv = edv; v.e_ifd = eid; v.e_dmd = edd;
    tbl.push_back(v);
  endtask

  // ---------------- behavioural model (random phase) ----------------
  logic [XLEN:0]   exp_q[$];
  bit              rand_en = 0, rand_done = 0;
  int              rand_left = 1500;
  int              wait_cnt = 0;
  int              m_owner = 0;  // 0 none, 1 fetch, 2 data
  int              m_starve = 0;
  logic            m_we = 0, m_ifv = 0, m_dmv = 0;
  logic [XLEN-1:0] m_addr = '0, m_wdata = '0, m_ifd = '0, m_dmd = '0;

  always @(posedge clk) begin
    if (rand_en) begin
      m_ifv = 0;
      m_dmv = 0;
      if (m_owner != 0) begin
        if (ack_drv) begin
          if (m_owner == 1) begin
            m_ifv = 1; m_ifd = rdata_drv;
            exp_q.push_back({1'b0, rdata_drv});
          end else begin
            m_dmv = 1;
            if (!m_we) m_dmd = rdata_drv;
            exp_q.push_back({1'b1, m_dmd});
          end
          m_owner = 0;
        end
      end else if (dm_req && !(m_starve == MAX_STARVE && if_req)) begin
        m_owner = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        m_starve = if_req ? ((m_starve < MAX_STARVE) ? m_starve + 1 : m_starve) : 0;
      end else if (if_req) begin
        m_owner = 1; m_we = 0; m_addr = if_addr; m_starve = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rand_en) begin
      logic [XLEN:0] got;
      chk("rnd_mem_req", mem_req_o, m_owner != 0);
      chk("rnd_state", dbg_state_o, m_owner);
      chk("rnd_mem_we", mem_we_o, m_we);
      chk("rnd_mem_addr", mem_addr_o, m_addr);
      chk("rnd_mem_wdata", mem_wdata_o, m_wdata);
      chk("rnd_if_valid", if_valid_o, m_ifv);
      chk("rnd_dm_valid", dm_valid_o, m_dmv);
      chk("rnd_if_rdata", if_rdata_o, m_ifd);
      chk("rnd_dm_rdata", dm_rdata_o, m_dmd);
      chk("rnd_stall_if", stall_if_o, if_req & ~m_ifv);
      chk("rnd_stall_dm", stall_dm_o, dm_req & ~m_dmv);
      chk("rnd_err", err_o, 1'b0);
      if (if_valid_o || dm_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("rnd_cpl_unexpected", {dm_valid_o, if_valid_o}, 2'b00);
        end else begin
          got = exp_q.pop_front();
          chk("rnd_cpl", {dm_valid_o, dm_valid_o ? dm_rdata_o : if_rdata_o}, got);
        end
      end
      // memory responder
      if (mem_req_o) begin
        if (wait_cnt == 0) begin ack_drv = 1; rdata_drv = $urandom; end
        else begin ack_drv = 0; wait_cnt--; end
      end else begin
        ack_drv = ($urandom_range(0, 3) == 0);
        rdata_drv = $urandom;
        wait_cnt = $urandom_range(0, 3);
      end
      // fetch requester
      if (if_req) begin
        if (if_valid_o) begin
          if ($urandom_range(0, 1) == 1) if_addr = $urandom_range(0, 255) << 2;
          else if_req = 0;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        if_req = 1; if_addr = $urandom_range(0, 255) << 2;
      end
      // data requester, biased toward back-to-back traffic
      if (dm_req) begin
        if (dm_valid_o) begin
          if ($urandom_range(0, 3) != 0) begin
            dm_we = $urandom_range(0, 1); dm_addr = $urandom_range(0, 255) << 2; dm_wdata = $urandom;
          end else dm_req = 0;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        dm_req = 1; dm_we = $urandom_range(0, 1);
        dm_addr = $urandom_range(0, 255) << 2; dm_wdata = $urandom;
      end
      rand_left--;
      if (rand_left == 0) begin
        rand_en = 0;
        rand_done = 1;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc, nv, k;
    bit gnt_dm[6];
    bit exp_order[6];

    do_reset();
    chk("reset_mem_req", mem_req_o, 0);
    chk("reset_mem_we", mem_we_o, 0);
    chk("reset_mem_addr", mem_addr_o, 0);
    chk("reset_mem_wdata", mem_wdata_o, 0);
    chk("reset_rdata", {if_rdata_o, dm_rdata_o}, 0);
    chk("reset_valid", {if_valid_o, dm_valid_o}, 0);
    chk("reset_err", err_o, 0);
    chk("reset_state", dbg_state_o, ARB_IDLE);

    // lone fetch; ack ignored in idle; DM read; simultaneous DM write + fetch
    add_vec(1, 32'h10, 0, 0, 0, 0,       0, 0,            1, 0, 32'h10, 0,  0, 0, 0,            0);
    add_vec(1, 32'h10, 0, 0, 0, 0,       1, 32'h00A00093, 0, 0, 32'h10, 0,  1, 0, 32'h00A00093, 0);
    add_vec(0, 0,      0, 0, 0, 0,       1, 32'hFFFF,     0, 0, 32'h10, 0,  0, 0, 32'h00A00093, 0);
    add_vec(0, 0,      1, 0, 32'h30, 32'h77, 0, 0,        1, 0, 32'h30, 32'h77, 0, 0, 32'h00A00093, 0);
    add_vec(0, 0,      1, 0, 32'h30, 32'h77, 1, 32'hCAFE, 0, 0, 32'h30, 32'h77, 0, 1, 32'h00A00093, 32'hCAFE);
    add_vec(1, 32'h40, 1, 1, 32'h20, 32'h5, 0, 0,         1, 1, 32'h20, 32'h5, 0, 0, 32'h00A00093, 32'hCAFE);
    add_vec(1, 32'h40, 1, 1, 32'h20, 32'h5, 1, 32'hDEAD,  0, 1, 32'h20, 32'h5, 0, 1, 32'h00A00093, 32'hCAFE);
    add_vec(1, 32'h40, 0, 0, 0, 0,       0, 0,            1, 0, 32'h40, 32'h5, 0, 0, 32'h00A00093, 32'hCAFE);
    add_vec(1, 32'h40, 0, 0, 0, 0,       1, 32'h1234,     0, 0, 32'h40, 32'h5, 1, 0, 32'h1234,     32'hCAFE);
    add_vec(0, 0,      0, 0, 0, 0,       0, 0,            0, 0, 32'h40, 32'h5, 0, 0, 32'h1234,     32'hCAFE);

    for (int i = 0; i < tbl.size(); i++) begin
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      dm_req = tbl[i].dm_req; dm_we = tbl[i].dm_we; dm_addr = tbl[i].dm_addr; dm_wdata = tbl[i].dm_wdata;
      ack_drv = tbl[i].ack; rdata_drv = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_mem_req", i), mem_req_o, tbl[i].e_req);
      chk($sformatf("vec%0d_mem_we", i), mem_we_o, tbl[i].e_we);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr_o, tbl[i].e_addr);
      chk($sformatf("vec%0d_mem_wdata", i), mem_wdata_o, tbl[i].e_wdata);
      chk($sformatf("vec%0d_valid", i), {if_valid_o, dm_valid_o}, {tbl[i].e_ifv, tbl[i].e_dmv});
      chk($sformatf("vec%0d_if_rdata", i), if_rdata_o, tbl[i].e_ifd);
      chk($sformatf("vec%0d_dm_rdata", i), dm_rdata_o, tbl[i].e_dmd);
      chk($sformatf("vec%0d_stall", i), {stall_if_o, stall_dm_o},
          {tbl[i].if_req & ~tbl[i].e_ifv, tbl[i].dm_req & ~tbl[i].e_dmv});
    end

    // starvation: continuous DM with IF waiting -> DM x4, IF, DM
    do_reset();
    comb_mode = 1;
    if_req = 1; if_addr = 32'h100;
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      @(negedge clk);
      if (mem_req_o) begin gnt_dm[k] = (mem_addr_o == 32'h200); k++; end
      if (if_valid_o) if_req = 0;
    end
    chk("starve_grant_count", k, 6);
    exp_order = '{1, 1, 1, 1, 0, 1};
    for (int g = 0; g < k; g++) chk($sformatf("starve_grant%0d_is_dm", g), gnt_dm[g], exp_order[g]);

    // reset while DM is in flight; a late ack must not produce a pulse
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h60;
    @(negedge clk);
    chk("rst_dm_granted", {mem_req_o, mem_addr_o}, {1'b1, 32'h60});
    @(posedge clk);
    #2;
    rst_i = 0; dm_req = 0;
    #1;
    chk("rst_async_outputs", {mem_req_o, mem_we_o, mem_addr_o, dm_valid_o, err_o}, 0);
    chk("rst_async_state", dbg_state_o, ARB_IDLE);
    @(negedge clk);
    rst_i = 1; ack_drv = 1; rdata_drv = 32'hBEEF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_late_ack", {mem_req_o, dm_valid_o, dm_rdata_o}, 0);
    end
    ack_drv = 0;

    // back-to-back fetches with same-cycle ack: one valid every 2 cycles
    do_reset();
    comb_mode = 1;
    if_req = 1; if_addr = 0;
    cyc = 0; nv = 0;
    for (int c = 0; c < 20 && nv < 3; c++) begin
      @(negedge clk);
      cyc++;
      if (mem_req_o) chk("b2b_addr", mem_addr_o, nv * 4);
      if (if_valid_o) begin
        chk("b2b_cycle", cyc, 2 + 2 * nv);
        chk("b2b_data", if_rdata_o, (nv * 4) ^ 32'hA5A5_0000);
        nv++;
        if (nv == 3) if_req = 0;
        else if_addr = nv * 4;
      end
    end
    chk("b2b_count", nv, 3);

    // randomized run against the model
    do_reset();
    rand_en = 1;
    for (int c = 0; c < 3000 && !rand_done; c++) @(posedge clk);
    chk("rnd_finished", rand_done, 1);
    rand_en = 0;
    chk("rnd_queue_empty", exp_q.size(), 0);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    if_req = 1; if_addr = 32'h44;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cyc++;
      if (if_valid_o) break;
    end
    chk("to_cycle", cyc, 9);
    chk("to_rdata_kept", if_rdata_o, 0);
    chk("to_mem_req", mem_req_o, 0);
    chk("to_err", err_o, 1);
    if_addr = 32'h48; comb_mode = 1;
    nv = 0;
    for (int c = 0; c < 10 && nv == 0; c++) begin
      @(negedge clk);
      if (if_valid_o) begin
        nv = 1;
        chk("to_next_data", if_rdata_o, 32'h48 ^ 32'hA5A5_0000);
      end
    end
    chk("to_next_served", nv, 1);
    if_req = 0;
    repeat (2) @(negedge clk);
    chk("to_err_sticky", err_o, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
